// File: rtl/sample_avg_40k.sv
// Moving average over the last 2^LOG2_TAPS audio samples, one new sample per rising edge of
// freq_40k. Three-stage pipeline: capture/history swap, running-sum update, scaled output.
`timescale 1ns / 1ps

module sample_avg_40k #(
  parameter int unsigned DW        = 16,
  parameter int unsigned LOG2_TAPS = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 freq_40k,
  input  logic signed [DW-1:0] din,
  input  logic                 clr,
  output logic signed [DW-1:0] dout,
  output logic                 dout_valid,
  output logic                 primed,
  output logic                 busy
);

  localparam int unsigned TAPS = 2 ** LOG2_TAPS;
  localparam int unsigned AW   = DW + LOG2_TAPS;
  localparam int unsigned PW   = LOG2_TAPS;
  localparam int unsigned CW   = LOG2_TAPS + 1;

  typedef enum logic [0:0] {StClear, StRun} state_e;

  state_e state_q, state_d;

  logic f_d1_q, f_d2_q;
  logic tick;

  logic [PW-1:0] clr_ptr_q, clr_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] fill_cnt_q, fill_cnt_d;

  logic signed [DW-1:0] s_new_q, s_new_d;
  logic signed [DW-1:0] s_old_q, s_old_d;
  logic                 v1_q, v1_d;
  logic                 v2_q, v2_d;
  logic                 full1_q, full1_d;
  logic                 full2_q, full2_d;

  logic signed [AW-1:0] acc_q, acc_d;
  logic signed [DW-1:0] dout_q, dout_d;
  logic                 dout_valid_q, dout_valid_d;
  logic                 primed_q, primed_d;

  logic signed [DW-1:0] hist_mem [TAPS];
  logic                 hist_we;
  logic [PW-1:0]        hist_waddr;
  logic signed [DW-1:0] hist_wdata;

  assign tick = f_d1_q & ~f_d2_q;

  always_comb begin
    state_d      = state_q;
    clr_ptr_d    = clr_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    fill_cnt_d   = fill_cnt_q;
    s_new_d      = s_new_q;
    s_old_d      = s_old_q;
    v1_d         = 1'b0;
    v2_d         = 1'b0;
    full1_d      = full1_q;
    full2_d      = full2_q;
    acc_d        = acc_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    primed_d     = primed_q;
    hist_we      = 1'b0;
    hist_waddr   = wr_ptr_q;
    hist_wdata   = din;

    unique case (state_q)
      StClear: begin
        // Zero one history slot per cycle; running state is held at its empty value.
        hist_we    = 1'b1;
        hist_waddr = clr_ptr_q;
        hist_wdata = '0;
        clr_ptr_d  = clr_ptr_q + PW'(1);
        acc_d      = '0;
        wr_ptr_d   = '0;
        fill_cnt_d = '0;
        primed_d   = 1'b0;
        if (clr_ptr_q == PW'(TAPS - 1)) begin
          state_d = StRun;
        end
      end

      StRun: begin
        if (clr) begin
          // Leaving the valid bits at their zero defaults drops every in-flight sample.
          state_d   = StClear;
          clr_ptr_d = '0;
          primed_d  = 1'b0;
        end else begin
          if (tick) begin
            s_new_d  = din;
            s_old_d  = hist_mem[wr_ptr_q];
            hist_we  = 1'b1;
            wr_ptr_d = wr_ptr_q + PW'(1);
            full1_d  = (fill_cnt_q >= CW'(TAPS - 1));
            if (fill_cnt_q < CW'(TAPS)) begin
              fill_cnt_d = fill_cnt_q + CW'(1);
            end
            v1_d = 1'b1;
          end

          if (v1_q) begin
            acc_d   = acc_q + AW'(s_new_q) - AW'(s_old_q);
            full2_d = full1_q;
            v2_d    = 1'b1;
          end

          if (v2_q) begin
            dout_d       = DW'(acc_q >>> LOG2_TAPS);
            dout_valid_d = 1'b1;
            if (full2_q) begin
              primed_d = 1'b1;
            end
          end
        end
      end

      default: state_d = StClear;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StClear;
      f_d1_q       <= 1'b0;
      f_d2_q       <= 1'b0;
      clr_ptr_q    <= '0;
      wr_ptr_q     <= '0;
      fill_cnt_q   <= '0;
      s_new_q      <= '0;
      s_old_q      <= '0;
      v1_q         <= 1'b0;
      v2_q         <= 1'b0;
      full1_q      <= 1'b0;
      full2_q      <= 1'b0;
      acc_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      primed_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      f_d1_q       <= freq_40k;
      f_d2_q       <= f_d1_q;
      clr_ptr_q    <= clr_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      fill_cnt_q   <= fill_cnt_d;
      s_new_q      <= s_new_d;
      s_old_q      <= s_old_d;
      v1_q         <= v1_d;
      v2_q         <= v2_d;
      full1_q      <= full1_d;
      full2_q      <= full2_d;
      acc_q        <= acc_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      primed_q     <= primed_d;
    end
  end

  // History storage has no reset: the CLEAR pass after reset zeroes it before first use.
  always_ff @(posedge clk) begin
    if (hist_we) begin
      hist_mem[hist_waddr] <= hist_wdata;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign primed     = primed_q;
  assign busy       = (state_q == StClear);

endmodule

// File: tb/tb_sample_avg_40k.sv
// Randomised bench for sample_avg_40k; expected averages come from a sample-history queue
// model with floor division, plus fixed end values for the directed scenarios.
`timescale 1ns / 1ps

module tb_sample_avg_40k;

  localparam int unsigned DW        = 16;
  localparam int unsigned LOG2_TAPS = 3;
  localparam int          TAPS      = 8;

  logic                 clk      = 1'b0;
  logic                 rst_n    = 1'b0;
  logic                 freq_40k = 1'b0;
  logic                 clr      = 1'b0;
  logic signed [DW-1:0] din      = '0;
  logic signed [DW-1:0] dout;
  logic                 dout_valid;
  logic                 primed;
  logic                 busy;

  typedef struct {
    int dout;
    int primed;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   hist[$];
  int   n_samp    = 0;
  int   n_checks  = 0;
  int   n_pass    = 0;
  int   cyc       = 0;
  int   last_dout = 0;

  sample_avg_40k #(
    .DW        (DW),
    .LOG2_TAPS (LOG2_TAPS)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .freq_40k   (freq_40k),
    .din        (din),
    .clr        (clr),
    .dout       (dout),
    .dout_valid (dout_valid),
    .primed     (primed),
    .busy       (busy)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int floor_div(input int s, input int d);
    int q;
    q = s / d;
    if ((s % d != 0) && (s < 0)) q--;
    return q;
  endfunction

  // Average over the last TAPS accepted samples, missing ones count as zero.
  function automatic void model_push(input int v, input int vcyc);
    exp_t e;
    int   sum;
    hist.push_back(v);
    if (hist.size() > TAPS) void'(hist.pop_front());
    n_samp++;
    sum = 0;
    foreach (hist[i]) sum += hist[i];
    e.dout   = floor_div(sum, TAPS);
    e.primed = (n_samp >= TAPS) ? 1 : 0;
    e.cyc    = vcyc;
    exp_q.push_back(e);
  endfunction

  function automatic void model_clear();
    hist.delete();
    n_samp = 0;
  endfunction

  function automatic int rand_val();
    return int'($urandom_range(65535)) - 32768;
  endfunction

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (dout_valid) begin
        if (exp_q.size() == 0) begin
          check_eq("spurious_valid", int'(dout_valid), 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check_eq("dout", int'(dout), e.dout);
          check_eq("primed", int'(primed), e.primed);
          check_eq("latency", cyc, e.cyc);
        end
        last_dout = int'(dout);
      end
    end
  endtask

  // Called at a negedge; the rise is sampled at the next posedge and the result is due 3 later.
  task automatic send(input int val, input int hi, input int lo);
    din      = DW'(val);
    freq_40k = 1'b1;
    model_push(val, cyc + 4);
    repeat (hi) @(negedge clk);
    freq_40k = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (busy && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (busy) check_eq("ready_timeout", int'(busy), 0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) check_eq("drain_timeout", exp_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic clr_idle();
    drain();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    model_clear();
    wait_ready();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    fork
      monitor();
    join_none

    // Reset state and the length of the initial clear pass.
    @(negedge clk);
    check_eq("rst_dout", int'(dout), 0);
    check_eq("rst_valid", int'(dout_valid), 0);
    check_eq("rst_primed", int'(primed), 0);
    check_eq("rst_busy", int'(busy), 1);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < TAPS + 4; i++) begin
      if (busy) n++;
      @(negedge clk);
    end
    check_eq("t1_busy_cycles", n, TAPS);
    check_eq("t1_dout", int'(dout), 0);

    // Step input at the real sample rate.
    for (int k = 0; k < 8; k++) send(800, 625, 625);
    drain();
    check_eq("t2_final", last_dout, 800);
    check_eq("t2_primed", int'(primed), 1);

    // Negative constant and rounding toward -inf.
    clr_idle();
    for (int k = 0; k < 8; k++) send(-3, 2, 3);
    drain();
    check_eq("t3_full", last_dout, -3);
    clr_idle();
    send(-3, 2, 2);
    drain();
    check_eq("t3_single", last_dout, -1);

    // Pointer wrap: oldest samples must leave the sum.
    clr_idle();
    for (int k = 0; k < 20; k++) send(k, int'($urandom_range(1, 3)), int'($urandom_range(1, 3)));
    drain();
    check_eq("t4_wrap", last_dout, 15);

    // Clear on the same cycle as a tick: sample dropped, buffer re-cleared.
    din      = DW'(555);
    freq_40k = 1'b1;
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    model_clear();
    n = 0;
    for (int i = 0; i < TAPS + 4; i++) begin
      if (busy) n++;
      if (i == 0) check_eq("t5_primed_drop", int'(primed), 0);
      @(negedge clk);
    end
    freq_40k = 1'b0;
    @(negedge clk);
    check_eq("t5_busy_cycles", n, TAPS);
    send(80, 2, 2);
    drain();
    check_eq("t5_after_clr", last_dout, 10);

    // Back-to-back ticks every second clock.
    clr_idle();
    for (int k = 0; k < 16; k++) send(8, 1, 1);
    drain();
    check_eq("t6_fast", last_dout, 8);

    // Reset while results are still in flight.
    for (int k = 0; k < 5; k++) send(rand_val(), 1, 1);
    n = 0;
    while (!dout_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    check_eq("t6_valid_seen", int'(dout_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_valid", int'(dout_valid), 0);
    check_eq("t6_rst_dout", int'(dout), 0);
    check_eq("t6_rst_busy", int'(busy), 1);
    check_eq("t6_rst_primed", int'(primed), 0);
    exp_q.delete();
    model_clear();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready();

    // Random samples, spacing and occasional idle clears.
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(7) == 0) clr_idle();
      send(rand_val(), int'($urandom_range(1, 4)), int'($urandom_range(1, 4)));
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
